// File: rtl/car_interlock_sequencer.sv
// rtl/car_interlock_sequencer.sv - car interlock: fault debounce, ignition FSM with bounded crank, pulsed chime
// Sits between raw vehicle sensors and the starter, dash and warning-lamp drivers.
module car_interlock_sequencer #(
    parameter int                N_WARN     = 8,
    parameter logic [N_WARN-1:0] PRI1_MASK  = 8'h0F,
    parameter int                DEB_CYCLES = 4,
    parameter int                CRANK_MAX  = 16,
    parameter int                CHIME_HALF = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_WARN-1:0] i_fault,
    input  logic              i_key,
    input  logic              i_brk,
    input  logic              i_park,
    input  logic              i_srv,
    input  logic              i_start_req,
    input  logic              i_eng_run,
    output logic [N_WARN-1:0] o_warn,
    output logic              o_warn_pri1,
    output logic              o_warn_pri2,
    output logic              o_start_permit,
    output logic              o_crank,
    output logic              o_engine_on,
    output logic              o_chime,
    output logic [2:0]        o_state
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int CR_W  = (CRANK_MAX > 1) ? $clog2(CRANK_MAX) : 1;
    localparam int CH_W  = $clog2(2 * CHIME_HALF);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CR_W-1:0]  CR_LAST  = CR_W'(CRANK_MAX - 1);
    localparam logic [CH_W-1:0]  CH_HALF  = CH_W'(CHIME_HALF);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(2 * CHIME_HALF - 1);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_READY    = 3'd1,
        ST_CRANKING = 3'd2,
        ST_RUN      = 3'd3,
        ST_LOCKOUT  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CR_W-1:0]     r_crank_cnt;
    logic [CR_W-1:0]     w_crank_cnt_nxt;
    logic [N_WARN-1:0]   r_warn;
    logic [DEB_W-1:0]    r_deb_cnt [N_WARN];
    logic                r_chime;
    logic [CH_W-1:0]     r_phase;
    logic                w_pri1;
    logic                w_pri2;
    logic                w_permit;
    logic                w_chime_cond;

    // A change is only accepted after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_warn <= '0;
            for (int i = 0; i < N_WARN; i++) r_deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_WARN; i++) begin
                if (i_fault[i] == r_warn[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_deb_cnt[i] <= '0;
                    r_warn[i]    <= i_fault[i];
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_pri1   = |(r_warn & PRI1_MASK);
    assign w_pri2   = |(r_warn & ~PRI1_MASK);
    assign w_permit = (r_state == ST_READY) & ~w_pri1 & i_park & i_brk & ~i_srv;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_OFF;
            r_crank_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_crank_cnt <= w_crank_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_crank_cnt_nxt = r_crank_cnt;
        if (!i_key) begin
            w_state_nxt = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:   w_state_nxt = ST_READY;
                ST_READY: begin
                    if (i_start_req && w_permit) begin
                        w_state_nxt     = ST_CRANKING;
                        w_crank_cnt_nxt = '0;
                    end
                end
                // Engine catching wins over a timeout on the same edge.
                ST_CRANKING: begin
                    if (i_eng_run) begin
                        w_state_nxt = ST_RUN;
                    end else if (!i_start_req) begin
                        w_state_nxt = ST_READY;
                    end else if (r_crank_cnt == CR_LAST) begin
                        w_state_nxt = ST_LOCKOUT;
                    end else begin
                        w_crank_cnt_nxt = r_crank_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!i_eng_run) w_state_nxt = ST_READY;
                end
                ST_LOCKOUT: w_state_nxt = ST_LOCKOUT;
                default:    w_state_nxt = ST_OFF;
            endcase
        end
    end

    assign w_chime_cond = i_key & (w_pri1 | (i_key & ~i_brk & (r_state == ST_READY))
                                  | (r_state == ST_LOCKOUT));

    // Phase restarts from zero whenever the condition drops, so every burst opens with a full high phase.
    always_ff @(posedge i_clk) begin
        if (i_rst || !w_chime_cond) begin
            r_chime <= 1'b0;
            r_phase <= '0;
        end else begin
            r_chime <= (r_phase < CH_HALF);
            r_phase <= (r_phase == CH_LAST) ? '0 : r_phase + 1'b1;
        end
    end

    assign o_warn         = r_warn;
    assign o_warn_pri1    = w_pri1;
    assign o_warn_pri2    = w_pri2;
    assign o_start_permit = w_permit;
    assign o_crank        = (r_state == ST_CRANKING);
    assign o_engine_on    = (r_state == ST_RUN);
    assign o_chime        = r_chime;
    assign o_state        = r_state;

endmodule
